// File: rtl/operand_load_stage.sv
// Operand load stage: forms execute operands from a load select code and presents them
// through a 2-entry skid buffer. Optional writeback forwarding: OPERAND_LOAD_FORWARD_EN.
module operand_load_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  load_sel,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rfa_data,
  input  logic [DATA_WIDTH-1:0] rfb_data,
  input  logic [4:0]            rfa_addr,
  input  logic [4:0]            rfb_addr,
  input  logic [DATA_WIDTH-1:0] next_pc,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [SEL_WIDTH-1:0] SEL_NEXTPC_IMM24  = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_IMM19     = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] SEL_NEXTPC_IMM21B = SEL_WIDTH'(3);
  localparam logic [SEL_WIDTH-1:0] SEL_NEXTPC_IMM21C = SEL_WIDTH'(4);
  localparam logic [SEL_WIDTH-1:0] SEL_NULL_COMBO    = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] SEL_NULL_RFB      = SEL_WIDTH'(6);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_IMM16A    = SEL_WIDTH'(7);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_IMM16B    = SEL_WIDTH'(8);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_IMM21A    = SEL_WIDTH'(9);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_IMM5      = SEL_WIDTH'(10);
  localparam logic [SEL_WIDTH-1:0] SEL_RFA_RFB       = SEL_WIDTH'(11);

  logic [1:0]            r_state;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic [DATA_WIDTH-1:0] r_main_a;
  logic [DATA_WIDTH-1:0] r_main_b;
  logic [DATA_WIDTH-1:0] r_skid_a;
  logic [DATA_WIDTH-1:0] r_skid_b;

  logic [1:0]            w_state_d;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_main_from_skid;
  logic [DATA_WIDTH-1:0] w_rfa;
  logic [DATA_WIDTH-1:0] w_rfb;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic                  w_unused;

`ifdef OPERAND_LOAD_FORWARD_EN
  // Bypass a same-cycle writeback; register 0 is hardwired and never forwarded.
  assign w_rfa = (wb_en && (wb_addr != 5'd0) && (wb_addr == rfa_addr)) ? wb_data : rfa_data;
  assign w_rfb = (wb_en && (wb_addr != 5'd0) && (wb_addr == rfb_addr)) ? wb_data : rfb_data;
  assign w_unused = ^instr[31:26];
`else
  assign w_rfa = rfa_data;
  assign w_rfb = rfb_data;
  assign w_unused = ^{instr[31:26], rfa_addr, rfb_addr, wb_en, wb_addr, wb_data};
`endif

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (load_sel)
      SEL_NEXTPC_IMM24: begin
        w_op_a = next_pc;
        w_op_b = {{(DATA_WIDTH-26){instr[23]}}, instr[23:0], 2'b00};
      end
      SEL_RFA_IMM19: begin
        w_op_a = w_rfa;
        w_op_b = {{(DATA_WIDTH-21){instr[18]}}, instr[18:0], 2'b00};
      end
      SEL_NEXTPC_IMM21B: begin
        w_op_a = next_pc;
        w_op_b = {{(DATA_WIDTH-21){instr[20]}}, instr[20:0]};
      end
      SEL_NEXTPC_IMM21C: begin
        w_op_a = next_pc;
        w_op_b = {{(DATA_WIDTH-21){instr[25]}}, instr[25:21], instr[15:0]};
      end
      SEL_NULL_COMBO: w_op_b = DATA_WIDTH'({instr[15:0], 16'h0000});
      SEL_NULL_RFB:   w_op_b = w_rfb;
      SEL_RFA_IMM16A: begin
        w_op_a = w_rfa;
        w_op_b = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
      end
      SEL_RFA_IMM16B: begin
        w_op_a = w_rfa;
        w_op_b = {{(DATA_WIDTH-16){instr[25]}}, instr[25:21], instr[10:0]};
      end
      SEL_RFA_IMM21A: begin
        w_op_a = w_rfa;
        w_op_b = {{(DATA_WIDTH-21){instr[20]}}, instr[20:0]};
      end
      SEL_RFA_IMM5: begin
        w_op_a = w_rfa;
        w_op_b = DATA_WIDTH'(instr[4:0]);
      end
      SEL_RFA_RFB: begin
        w_op_a = w_rfa;
        w_op_b = w_rfb;
      end
      default: ;
    endcase
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_comb begin
    w_state_d        = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_d   = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_d   = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_state_d        = ST_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_d = ST_EMPTY;
    endcase
    // Flush overrides everything, including a same-cycle acceptance.
    if (flush) begin
      w_state_d        = ST_EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_a    <= '0;
      r_main_b    <= '0;
      r_skid_a    <= '0;
      r_skid_b    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= (w_state_d != ST_EMPTY);
      r_in_ready  <= (w_state_d != ST_FULL);
      if (w_load_main) begin
        r_main_a <= w_op_a;
        r_main_b <= w_op_b;
      end else if (w_main_from_skid) begin
        r_main_a <= r_skid_a;
        r_main_b <= r_skid_b;
      end
      if (w_load_skid) begin
        r_skid_a <= w_op_a;
        r_skid_b <= w_op_b;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign operand_a = r_main_a;
  assign operand_b = r_main_b;

endmodule

// File: tb/tb_operand_load_stage.sv
// Self-checking bench for operand_load_stage: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_operand_load_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  load_sel;
  logic [31:0] instr;
  logic [31:0] rfa_data;
  logic [31:0] rfb_data;
  logic [4:0]  rfa_addr;
  logic [4:0]  rfb_addr;
  logic [31:0] next_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [63:0] q[$];

  operand_load_stage #(
    .DATA_WIDTH(32),
    .SEL_WIDTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load_sel (load_sel),
    .instr    (instr),
    .rfa_data (rfa_data),
    .rfb_data (rfb_data),
    .rfa_addr (rfa_addr),
    .rfb_addr (rfb_addr),
    .next_pc  (next_pc),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .operand_a(operand_a),
    .operand_b(operand_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    return v[n-1] ? v - (32'd1 << n) : v;
  endfunction

  // Reference operand table: {A, B} for a given select code.
  function automatic logic [63:0] model_ops(input logic [3:0] sel, input logic [31:0] ins,
                                            input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [31:0] pc);
    logic [31:0] a;
    logic [31:0] b;
    a = 32'd0;
    b = 32'd0;
    case (sel)
      4'd1:  begin a = pc; b = sx(ins & 32'hFF_FFFF, 24) * 4; end
      4'd2:  begin a = ra; b = sx(ins & 32'h7_FFFF, 19) * 4; end
      4'd3:  begin a = pc; b = sx(ins & 32'h1F_FFFF, 21); end
      4'd4:  begin a = pc; b = sx(((ins >> 21) & 32'd31) * 65536 + (ins & 32'hFFFF), 21); end
      4'd5:  b = (ins & 32'hFFFF) * 65536;
      4'd6:  b = rb;
      4'd7:  begin a = ra; b = sx(ins & 32'hFFFF, 16); end
      4'd8:  begin a = ra; b = sx(((ins >> 21) & 32'd31) * 2048 + (ins & 32'h7FF), 16); end
      4'd9:  begin a = ra; b = sx(ins & 32'h1F_FFFF, 21); end
      4'd10: begin a = ra; b = ins & 32'd31; end
      4'd11: begin a = ra; b = rb; end
      default: ;
    endcase
    return {a, b};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, "_operand_a"}, operand_a, q[0][63:32]);
      chk({tag, "_operand_b"}, operand_b, q[0][31:0]);
    end
  endtask

  // Advance the model with the currently driven inputs, clock once, check at negedge.
  task automatic tick(input string tag);
    logic [31:0] ra;
    logic [31:0] rb;
    bit acc;
    bit drn;
    ra = rfa_data;
    rb = rfb_data;
`ifdef OPERAND_LOAD_FORWARD_EN
    if (wb_en && wb_addr != 5'd0 && wb_addr == rfa_addr) ra = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rfb_addr) rb = wb_data;
`endif
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) begin
        void'(q.pop_front());
        delivered++;
      end
      if (acc) q.push_back(model_ops(load_sel, instr, ra, rb, next_pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic set_rr(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    load_sel = sel;
    rfa_data = a;
    rfb_data = b;
  endtask

  initial begin
    int d0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; load_sel = 4'd0; instr = 32'd0;
    rfa_data = 32'd0; rfb_data = 32'd0; rfa_addr = 5'd0; rfb_addr = 5'd0; next_pc = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    reset = 1'b1;

    // Basic accept right after reset release
    set_rr(4'd11, 32'h10, 32'h20); in_valid = 1'b1; out_ready = 1'b1;
    tick("basic");
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_a", operand_a, 32'h10);
    chk("basic_b", operand_b, 32'h20);
    in_valid = 1'b0;
    tick("basic_idle");
    chk("basic_idle_valid", 32'(out_valid), 32'd0);

    // Immediate forms
    load_sel = 4'd1; next_pc = 32'h1004; instr = 32'h00FF_FFFF; in_valid = 1'b1;
    tick("imm24");
    chk("imm24_a", operand_a, 32'h1004);
    chk("imm24_b", operand_b, 32'hFFFF_FFFC);
    load_sel = 4'd5; instr = 32'h0000_ABCD;
    tick("combo");
    chk("combo_a", operand_a, 32'h0);
    chk("combo_b", operand_b, 32'hABCD_0000);
    in_valid = 1'b0;
    tick("combo_idle");

    // Backpressure: three back-to-back entries with execute stalled
    out_ready = 1'b0; in_valid = 1'b1;
    set_rr(4'd11, 32'h100, 32'h200); tick("bp0");
    set_rr(4'd11, 32'h101, 32'h201); tick("bp1");
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    set_rr(4'd11, 32'h102, 32'h202); tick("bp2");
    chk("bp_hold_a", operand_a, 32'h100);
    d0 = delivered;
    out_ready = 1'b1;
    tick("bp_drain0");
    chk("bp_drain0_a", operand_a, 32'h101);
    tick("bp_drain1");
    chk("bp_drain1_a", operand_a, 32'h102);
    in_valid = 1'b0;
    tick("bp_drain2");
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_delivered", 32'(delivered - d0), 32'd3);

    // Flush while FULL with a same-cycle accept attempt
    out_ready = 1'b0; in_valid = 1'b1;
    set_rr(4'd11, 32'h300, 32'h400); tick("fl0");
    set_rr(4'd11, 32'h301, 32'h401); tick("fl1");
    flush = 1'b1;
    tick("flush");
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick("flush_after");
    chk("flush_nothing", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    set_rr(4'd7, 32'h55AA, 32'h0); instr = 32'h0000_8001; tick("ar0");
    set_rr(4'd11, 32'h66BB, 32'h77CC); tick("ar1");
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_a", operand_a, 32'd0);
    chk("arst_b", operand_b, 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Writeback forwarding on port A
    out_ready = 1'b1; in_valid = 1'b1;
    set_rr(4'd7, 32'h1, 32'h0); instr = 32'h0;
    rfa_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    tick("fwd");
`ifdef OPERAND_LOAD_FORWARD_EN
    chk("fwd_a", operand_a, 32'h55);
`else
    chk("fwd_a", operand_a, 32'h1);
`endif
    wb_addr = 5'd0;
    tick("fwd_r0");
    chk("fwd_r0_a", operand_a, 32'h1);
    in_valid = 1'b0; wb_en = 1'b0;
    tick("fwd_idle");

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      load_sel  = 4'($urandom_range(0, 15));
      instr     = $urandom;
      rfa_data  = $urandom;
      rfb_data  = $urandom;
      next_pc   = $urandom;
      rfa_addr  = 5'($urandom_range(0, 3));
      rfb_addr  = 5'($urandom_range(0, 3));
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
